// File: rtl/booth_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// FSM state encoding, Booth digit encodings and the digit-count helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Radix-4 Booth digit encodings (b[2i+1], b[2i], b[2i-1]).
    localparam logic [2:0] DIG_ZERO_0 = 3'b000;
    localparam logic [2:0] DIG_PA_0   = 3'b001;
    localparam logic [2:0] DIG_PA_1   = 3'b010;
    localparam logic [2:0] DIG_P2A    = 3'b011;
    localparam logic [2:0] DIG_M2A    = 3'b100;
    localparam logic [2:0] DIG_MA_0   = 3'b101;
    localparam logic [2:0] DIG_MA_1   = 3'b110;
    localparam logic [2:0] DIG_ZERO_1 = 3'b111;

    // Number of Booth digits for an unsigned operand of the given width,
    // including the extra digit that absorbs the zero extension.
    function automatic int booth_ndig(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Radix-4 Booth partial-product selector: maps one 3-bit digit and the
// unsigned multiplicand to a two's complement partial product in {0,+-A,+-2A}.
module booth_pp_select
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       digit,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH+1:0] pp
);

    logic signed [WIDTH+1:0] pos1;
    logic signed [WIDTH+1:0] pos2;

    // +A and +2A both fit as positive values in WIDTH+2 bits.
    assign pos1 = signed'({2'b00, mcand});
    assign pos2 = signed'({1'b0, mcand, 1'b0});

    // Decode the digit into the selected multiple of the multiplicand.
    always_comb begin
        pp = '0;
        case (digit)
            DIG_ZERO_0, DIG_ZERO_1: pp = '0;
            DIG_PA_0, DIG_PA_1:     pp = pos1;
            DIG_P2A:                pp = pos2;
            DIG_M2A:                pp = -pos2;
            DIG_MA_0, DIG_MA_1:     pp = -pos1;
            default:                pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_iter_mul.sv
// Iterative radix-4 Booth multiplier: one shared partial-product selector
// walks the multiplier digits one per cycle and accumulates the shifted
// partial products; result leaves through a valid/ready handshake.
module booth_iter_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NDIG  = booth_ndig(WIDTH);
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [WIDTH-1:0]          mcand;
    logic [WIDTH+2:0]          bext;
    logic [WIDTH+1:0]          pp;
    logic signed [ACC_W-1:0]   pp_sh;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic [2*WIDTH-1:0]        product_q;
    logic                      accept;
    logic                      last_dig;

    // bext is shifted right two bits per digit, so the current digit is
    // always its low three bits.
    booth_pp_select #(.WIDTH(WIDTH)) u_pp_select (
        .digit (bext[2:0]),
        .mcand (mcand),
        .pp    (pp)
    );

    assign accept   = (state == IDLE) && in_valid;
    assign last_dig = (state == RUN) && (cnt == LAST);

    // Sign-extend the partial product and align it to digit weight 4^cnt.
    always_comb begin
        pp_sh   = signed'({{WIDTH{pp[WIDTH+1]}}, pp}) <<< {cnt, 1'b0};
        acc_nxt = acc + pp_sh;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, step digits in RUN, hold in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, digit stepping, accumulation and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mcand     <= '0;
            bext      <= '0;
            acc       <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand <= a;
            bext  <= {2'b00, b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc  <= acc_nxt;
            cnt  <= cnt + CNT_W'(1);
            bext <= bext >> 2;
            if (last_dig) begin
                product_q <= acc_nxt[2*WIDTH-1:0];
            end
        end
    end

    // All handshake outputs are decoded from state alone.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_booth_iter_mul.sv
// Self-checking bench for booth_iter_mul (WIDTH=8 and WIDTH=4 instances).
module tb_booth_iter_mul;

    localparam int NDIG8 = 5;
    localparam int NDIG4 = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv8, ir8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    logic        iv4, ir4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    // Behavioural model for the WIDTH=8 instance
    int          m_phase = 0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_prod = '0;
    int          n_acc = 0;
    int          n_abort = 0;
    int          n_out = 0;

    always #5 clk = ~clk;

    booth_iter_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8),
        .product(prod8), .busy(busy8)
    );

    booth_iter_mul #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4),
        .product(prod4), .busy(busy4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1..NDIG computing, NDIG+1 holding the result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (m_phase != 0) n_abort <= n_abort + 1;
            m_phase <= 0;
            m_prod  <= '0;
        end else if (m_phase == 0) begin
            if (iv8) begin
                m_phase <= 1;
                m_pend  <= {8'h00, a8} * {8'h00, b8};
                n_acc   <= n_acc + 1;
            end
        end else if (m_phase <= NDIG8) begin
            m_phase <= m_phase + 1;
            if (m_phase == NDIG8) m_prod <= m_pend;
        end else if (or8) begin
            m_phase <= 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && ov8 && or8) n_out <= n_out + 1;
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out_valid", 64'(ov8), 64'(m_phase == NDIG8 + 1));
            chk("cyc_busy", 64'(busy8), 64'(m_phase != 0));
            chk("cyc_product", 64'(prod8), 64'(m_prod));
            if (rst_n) chk("cyc_in_ready", 64'(ir8), 64'(m_phase == 0));
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n;
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(ir8), 64'd1);
        a8 = a; b8 = b; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        n = 1;
        while (!ov8 && n < 20) begin @(posedge clk); #1; n++; end
        chk("latency8", 64'(n), 64'(NDIG8 + 1));
        chk("product8", 64'(prod8), 64'(exp));
        @(posedge clk); #1;
        chk("ov_one_cycle", 64'(ov8), 64'd0);
        chk("in_ready_back", 64'(ir8), 64'd1);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        int n;
        @(posedge clk); #1;
        a4 = a; b4 = b; iv4 = 1'b1; or4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        n = 1;
        while (!ov4 && n < 20) begin @(posedge clk); #1; n++; end
        chk("latency4", 64'(n), 64'(NDIG4 + 1));
        chk("product4", 64'(prod4), 64'(exp));
        @(posedge clk); #1;
        chk("ov4_cleared", 64'(ov4), 64'd0);
        chk("in_ready4_back", 64'(ir4), 64'd1);
    endtask

    task automatic wait_ov8();
        int n;
        n = 0;
        while (!ov8 && n < 20) begin @(posedge clk); #1; n++; end
        chk("wait_ov8_bound", 64'(ov8), 64'd1);
    endtask

    initial begin
        int target, cyc;
        iv8 = 0; or8 = 1; a8 = 0; b8 = 0;
        iv4 = 0; or4 = 1; a4 = 0; b4 = 0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_out_valid", 64'(ov8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_product", 64'(prod8), 64'd0);
        chk("rst_out_valid4", 64'(ov4), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", 64'(ir8), 64'd1);

        // Basic and corner operands
        op8(8'd13, 8'd11, 16'h008F);
        chk("model_pin_basic", 64'(m_prod), 64'h008F);
        op8(8'hFF, 8'hFF, 16'hFE01);
        chk("model_pin_ffff", 64'(m_prod), 64'hFE01);
        op8(8'h00, 8'hFF, 16'h0000);
        op8(8'h80, 8'h80, 16'h4000);
        op8(8'h01, 8'hAA, 16'h00AA);

        // Backpressure with a pending input pair
        @(posedge clk); #1;
        a8 = 8'd7; b8 = 8'd9; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        wait_ov8();
        chk("bp_product", 64'(prod8), 64'h003F);
        a8 = 8'd5; b8 = 8'd5; iv8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid_hold", 64'(ov8), 64'd1);
            chk("bp_product_hold", 64'(prod8), 64'h003F);
            chk("bp_in_ready_low", 64'(ir8), 64'd0);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_released_ov", 64'(ov8), 64'd0);
        chk("bp_released_ir", 64'(ir8), 64'd1);
        @(posedge clk); #1;
        chk("bp_pending_accepted", 64'(busy8), 64'd1);
        iv8 = 1'b0;
        wait_ov8();
        chk("bp_second_product", 64'(prod8), 64'h0019);
        @(posedge clk); #1;

        // Reset in the middle of RUN
        a8 = 8'd200; b8 = 8'd100; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(ov8), 64'd0);
        chk("abort_product", 64'(prod8), 64'd0);
        chk("abort_busy", 64'(busy8), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 64'(ir8), 64'd1);
        repeat (10) begin @(posedge clk); #1; end
        chk("abort_no_stale", 64'(prod8), 64'd0);

        // Minimum width instance
        op4(4'd15, 4'd15, 8'hE1);
        op4(4'd9, 4'd6, 8'h36);

        // Random pairs with random output stalls
        target = n_acc + 1000;
        cyc = 0;
        while (n_acc < target && cyc < 40000) begin
            @(posedge clk); #1;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            iv8 = ($urandom_range(0, 3) != 0);
            or8 = 1'($urandom_range(0, 1));
            cyc++;
        end
        chk("random_budget", 64'(n_acc >= target), 64'd1);
        iv8 = 1'b0;
        or8 = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        chk("one_output_per_input", 64'(n_out), 64'(n_acc - n_abort));
        chk("final_idle", 64'(ir8), 64'd1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
